test2_bist: RTL

Built-in self-test wrapper stage for the 4-input/1-output `test2` combinational block. It drives test patterns directly into `test2`'s A–D inputs and compacts its Y response into a MISR signature. At the end of a run it compares the signature with a golden value, so `test2` can be tested in silicon without the STIL/TetraMAX pattern flow.

---
 rtl/test2_bist_pkg.sv | 27 ++
 rtl/test2_misr.sv | 43 ++++
 rtl/test2_bist.sv | 138 +++++++++++++
 3 files changed

// File: rtl/test2_bist_pkg.sv
// Shared types and constants for the test2 BIST wrapper.
// Build option: TEST2_BIST_ZERO_PATTERN_EN prepends the all-zero pattern (16 patterns instead of 15).
package test2_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam logic [3:0]  LFSR_SEED         = 4'b0001;
  // x^4 + x^3 + 1: feedback = q[3] ^ q[2]
  localparam logic [3:0]  LFSR_TAPS         = 4'b1100;
  localparam logic [15:0] DEFAULT_MISR_POLY = 16'h1021;

`ifdef TEST2_BIST_ZERO_PATTERN_EN
  localparam int unsigned NPATTERNS = 16;
`else
  localparam int unsigned NPATTERNS = 15;
`endif

  function automatic logic [3:0] lfsr_next(input logic [3:0] q);
    return {q[2:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/test2_misr.sv
// Multiple-input signature register compacting the test2 response.
// Ports: clk, rst_n (sync, active-low), clr (zero signature), en (absorb data),
//        data[NOUTPUTS] (response), sig[MISR_W] (current signature).
module test2_misr
  import test2_bist_pkg::*;
#(
  parameter int unsigned          MISR_W    = 16,
  parameter logic [MISR_W-1:0]    MISR_POLY = MISR_W'(DEFAULT_MISR_POLY),
  parameter int unsigned          NOUTPUTS  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  input  logic [NOUTPUTS-1:0] data,
  output logic [MISR_W-1:0]   sig
);

  logic [MISR_W-1:0] sig_q;
  logic [MISR_W-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = {sig_q[MISR_W-2:0], 1'b0}
            ^ (sig_q[MISR_W-1] ? MISR_POLY : '0)
            ^ MISR_W'(data);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/test2_bist.sv
// BIST wrapper for the combinational test2 block: drives LFSR patterns into
// test2 A..D, compacts Y in a MISR and compares against GOLDEN_SIG.
// Ports: clk, rst_n (sync, active-low), start (level), dut_y (test2 Y),
//        pattern (bit3=A..bit0=D), busy, done, pass (valid with done),
//        signature (live MISR), pattern_index (index of applied pattern).
// Build option: TEST2_BIST_ZERO_PATTERN_EN drives 4'b0000 before the LFSR patterns.
module test2_bist
  import test2_bist_pkg::*;
#(
  parameter int unsigned       NINPUTS    = 4,
  parameter int unsigned       NOUTPUTS   = 1,
  parameter int unsigned       MISR_W     = 16,
  parameter logic [MISR_W-1:0] MISR_POLY  = MISR_W'(DEFAULT_MISR_POLY),
  parameter logic [MISR_W-1:0] GOLDEN_SIG = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [NOUTPUTS-1:0] dut_y,
  output logic [NINPUTS-1:0]  pattern,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [MISR_W-1:0]   signature,
  output logic [4:0]          pattern_index
);

  // lfsr_q always holds the pattern that will be driven on the next RUN cycle,
  // so both build variants share the same RUN-state update.
`ifdef TEST2_BIST_ZERO_PATTERN_EN
  localparam logic [3:0] FIRST_PATTERN = '0;
  localparam logic [3:0] FIRST_LFSR    = LFSR_SEED;
`else
  localparam logic [3:0] FIRST_PATTERN = LFSR_SEED;
  localparam logic [3:0] FIRST_LFSR    = lfsr_next(LFSR_SEED);
`endif
  localparam logic [4:0] LAST_INDEX = 5'(NPATTERNS - 1);

  state_e               state_q, state_d;
  logic [NINPUTS-1:0]   pattern_q, pattern_d;
  logic [3:0]           lfsr_q, lfsr_d;
  logic [4:0]           index_q, index_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 misr_clr;
  logic                 misr_en;

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    lfsr_d    = lfsr_q;
    index_d   = index_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    misr_clr  = 1'b0;
    misr_en   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_IDLE) begin
          misr_clr  = 1'b1;
          index_d   = '0;
          pattern_d = '0;
        end
        if (start) begin
          state_d   = ST_RUN;
          misr_clr  = 1'b1;
          index_d   = '0;
          pattern_d = FIRST_PATTERN;
          lfsr_d    = FIRST_LFSR;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
        end
      end
      ST_RUN: begin
        misr_en = 1'b1;
        index_d = index_q + 5'd1;
        if (index_q == LAST_INDEX) begin
          state_d   = ST_CHECK;
          pattern_d = '0;
        end else begin
          pattern_d = lfsr_q;
          lfsr_d    = lfsr_next(lfsr_q);
        end
      end
      ST_CHECK: begin
        pass_d  = (signature == GOLDEN_SIG);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pattern_q <= '0;
      lfsr_q    <= LFSR_SEED;
      index_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      lfsr_q    <= lfsr_d;
      index_q   <= index_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  test2_misr #(
    .MISR_W   (MISR_W),
    .MISR_POLY(MISR_POLY),
    .NOUTPUTS (NOUTPUTS)
  ) u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (misr_clr),
    .en   (misr_en),
    .data (dut_y),
    .sig  (signature)
  );

  assign pattern       = pattern_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign pattern_index = index_q;

endmodule
